axi_lite_regbank: RTL
=====================

Name: axi_lite_regbank

Overview:
- Parametrised AXI4-Lite slave register bank; generalises the fixed 4-register example slave.
- Configurable register count and data width; byte-strobe writes; top registers read-only status inputs.
- Out-of-range and read-only-write accesses return SLVERR.
- Sits behind the AXI interconnect as a control/status block for downstream datapath logic.

Parameters:
- C_DATA_WIDTH, 32, AXI data width in bits; 32 or 64.
- C_NUM_REGS, 16, total register count; power of two, 4..256.
- C_NUM_RO, 4, number of top registers that are read-only status; 0..C_NUM_REGS-1.
- C_ADDR_WIDTH, 8, AXI address width; must be >= log2(C_NUM_REGS)+log2(C_DATA_WIDTH/8).

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  synchronous active-low reset
- S_AXI_AWADDR  in  C_ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write-address handshake
- S_AXI_WDATA  in  C_DATA_WIDTH  write data
- S_AXI_WSTRB  in  C_DATA_WIDTH/8  byte strobes
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write-data handshake
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write-response handshake
- S_AXI_ARADDR  in  C_ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read-address handshake
- S_AXI_RDATA  out  C_DATA_WIDTH  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read-data handshake
- reg_out  out  (C_NUM_REGS-C_NUM_RO)*C_DATA_WIDTH  flat RW register contents; reg 0 at LSBs
- reg_wr_pulse  out  C_NUM_REGS-C_NUM_RO  one-cycle strobe per RW register on commit
- status_in  in  C_NUM_RO*C_DATA_WIDTH  flat RO register values; sampled on read

Behaviour:
- Clock and reset: single clock ACLK; ARESETN synchronous active-low.
- Reset: all RW registers 0, AWREADY/WREADY/BVALID/ARREADY/RVALID 0, BRESP/RRESP 0, RDATA 0, reg_wr_pulse 0.
- AWREADY and ARREADY rise one cycle after reset deassertion.
- Address decode: index = addr[ADDR_LSB +: log2(C_NUM_REGS)], ADDR_LSB = log2(C_DATA_WIDTH/8).
- Address bits above the index must be zero, else out-of-range. Low ADDR_LSB bits are ignored.
- Write channel: independent 1-deep holding registers for AW and W.
  - AWREADY = ~aw_held; WREADY = ~w_held. AW and W may arrive in either order or in the same cycle.
  - Commit at the first edge where aw_held & w_held & ~BVALID. That edge updates the register, pulses reg_wr_pulse[idx] for one cycle, sets BVALID, and clears both held flags.
  - Best case: AW+W handshake at edge N; register and BVALID updated at edge N+1.
- Write data: byte lane b is written iff WSTRB[b]. WSTRB=0 still commits, returns OKAY, and pulses reg_wr_pulse.
- Write response: BRESP = OKAY (00) for an RW index; SLVERR (10) for an RO index or out-of-range, with no register change and no pulse.
  - BVALID holds until BREADY. No new commit while BVALID=1; holding registers may still fill.
- Read channel: ARREADY = ~RVALID. On AR handshake at edge N, RDATA/RRESP/RVALID are valid at edge N+1 and held until RREADY.
  - RW index: returns the register value.
  - RO index: returns status_in slice sampled at edge N.
  - Out-of-range: RDATA=0, RRESP=SLVERR.
- Simultaneous read and write commit to the same register in one cycle: the read returns the pre-write value.
- Reset asserted mid-transaction: pending AW/W/AR are dropped, BVALID/RVALID forced 0 next edge, registers return to 0.

Optional Feature:
- Macro: REGBANK_SELF_CLEAR_EN.
- Defined: register 0 is a command register. Any bit written 1 reads back 1 for exactly one cycle after commit, then auto-clears to 0. reg_out reflects the pulse.
- Not defined: register 0 is an ordinary RW register.

Test Plan:
- Defaults: write 0x1,0x2,0x3,0x4 to addr 0x00,0x04,0x08,0x0C, then read back -> each BRESP=00, RDATA matches, RRESP=00, reg_wr_pulse[0..3] each high one cycle.
- Write 0xAABBCCDD to 0x10, then 0x11223344 with WSTRB=0101 -> read 0x10 returns 0xAA22CC44.
- W issued 3 cycles before AW to 0x14 data 0x5A5A5A5A -> WREADY drops after W handshake; BVALID one edge after AW handshake; read 0x14 returns 0x5A5A5A5A.
- status_in reg 12 = 0xDEADBEEF: write 0x0 to 0x30 -> BRESP=10, read 0x30 returns 0xDEADBEEF. Read 0x40 (out-of-range) -> RDATA=0, RRESP=10.
- Hold BREADY=0 for 10 cycles after a write, then issue a second AW/W -> second commit waits; exactly two BVALID pulses; final register value equals second data.
- With REGBANK_SELF_CLEAR_EN defined: write 0x1 to 0x00 -> reg_out[0] high one cycle; immediate read of 0x00 returns 0. Assert ARESETN=0 while BVALID pending -> BVALID 0 next edge, all registers 0.

Source files
------------

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite register bank: C_NUM_REGS words, the top C_NUM_RO are read-only status_in slices.
// Write commits 1 edge after both AW and W are held, and read data is registered on the AR edge.
// Backpressure: AW/W 1-deep holding, no commit while BVALID, ARREADY=~RVALID. REGBANK_SELF_CLEAR_EN turns reg 0 into a self-clearing command reg.
module axi_lite_regbank #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_NUM_REGS   = 16,
  parameter int C_NUM_RO     = 4,
  parameter int C_ADDR_WIDTH = 8
) (
  input  logic                                         ACLK,
  input  logic                                         ARESETN,
  input  logic [C_ADDR_WIDTH-1:0]                      S_AXI_AWADDR,
  input  logic [2:0]                                   S_AXI_AWPROT,
  input  logic                                         S_AXI_AWVALID,
  output logic                                         S_AXI_AWREADY,
  input  logic [C_DATA_WIDTH-1:0]                      S_AXI_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]                    S_AXI_WSTRB,
  input  logic                                         S_AXI_WVALID,
  output logic                                         S_AXI_WREADY,
  output logic [1:0]                                   S_AXI_BRESP,
  output logic                                         S_AXI_BVALID,
  input  logic                                         S_AXI_BREADY,
  input  logic [C_ADDR_WIDTH-1:0]                      S_AXI_ARADDR,
  input  logic [2:0]                                   S_AXI_ARPROT,
  input  logic                                         S_AXI_ARVALID,
  output logic                                         S_AXI_ARREADY,
  output logic [C_DATA_WIDTH-1:0]                      S_AXI_RDATA,
  output logic [1:0]                                   S_AXI_RRESP,
  output logic                                         S_AXI_RVALID,
  input  logic                                         S_AXI_RREADY,
  output logic [(C_NUM_REGS-C_NUM_RO)*C_DATA_WIDTH-1:0] reg_out,
  output logic [C_NUM_REGS-C_NUM_RO-1:0]               reg_wr_pulse,
  input  logic [(C_NUM_RO>0 ? C_NUM_RO : 1)*C_DATA_WIDTH-1:0] status_in
);

  localparam int STRB_W   = C_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(C_NUM_REGS);
  localparam int IDX_HI   = ADDR_LSB + IDX_W;
  localparam int NUM_RW   = C_NUM_REGS - C_NUM_RO;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                    ready_en;
  logic                    aw_held;
  logic                    w_held;
  logic                    commit;
  logic                    aw_ok;
  logic                    ar_in_range;
  logic [C_ADDR_WIDTH-1:0] aw_addr_q;
  logic [C_DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]       w_strb_q;
  logic [IDX_W-1:0]        aw_idx;
  logic [IDX_W-1:0]        ar_idx;
  logic [C_DATA_WIDTH-1:0] regs   [NUM_RW];
  logic [C_DATA_WIDTH-1:0] rd_mux [C_NUM_REGS];

  // ready_en keeps the address/data channels closed until one edge after reset release
  assign S_AXI_AWREADY = ready_en & ~aw_held;
  assign S_AXI_WREADY  = ready_en & ~w_held;
  assign S_AXI_ARREADY = ready_en & ~S_AXI_RVALID;

  assign aw_idx      = aw_addr_q[ADDR_LSB +: IDX_W];
  assign ar_idx      = S_AXI_ARADDR[ADDR_LSB +: IDX_W];
  assign aw_ok       = ((aw_addr_q >> IDX_HI) == '0) && (int'(aw_idx) < NUM_RW);
  assign ar_in_range = ((S_AXI_ARADDR >> IDX_HI) == '0);
  assign commit      = aw_held & w_held & ~S_AXI_BVALID;

  for (genvar i = 0; i < NUM_RW; i++) begin : g_rw
    assign reg_out[i*C_DATA_WIDTH +: C_DATA_WIDTH] = regs[i];
    assign rd_mux[i] = regs[i];
  end

  for (genvar i = NUM_RW; i < C_NUM_REGS; i++) begin : g_ro
    assign rd_mux[i] = status_in[(i-NUM_RW)*C_DATA_WIDTH +: C_DATA_WIDTH];
  end

  wire unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                     aw_addr_q[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      ready_en     <= 1'b0;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RRESP  <= RESP_OKAY;
      S_AXI_RDATA  <= '0;
      reg_wr_pulse <= '0;
      for (int i = 0; i < NUM_RW; i++) regs[i] <= '0;
    end else begin
      ready_en     <= 1'b1;
      reg_wr_pulse <= '0;
`ifdef REGBANK_SELF_CLEAR_EN
      // command bits live for the single cycle after their commit
      regs[0] <= '0;
`endif

      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        aw_held   <= 1'b1;
        aw_addr_q <= S_AXI_AWADDR;
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        w_held   <= 1'b1;
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end

      if (S_AXI_BVALID && S_AXI_BREADY) S_AXI_BVALID <= 1'b0;

      if (commit) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        S_AXI_BVALID <= 1'b1;
        if (aw_ok) begin
          S_AXI_BRESP          <= RESP_OKAY;
          reg_wr_pulse[aw_idx] <= 1'b1;
          for (int b = 0; b < STRB_W; b++)
            if (w_strb_q[b]) regs[aw_idx][8*b +: 8] <= w_data_q[8*b +: 8];
        end else begin
          S_AXI_BRESP <= RESP_SLVERR;
        end
      end

      if (S_AXI_RVALID && S_AXI_RREADY) S_AXI_RVALID <= 1'b0;

      // rd_mux sees regs before this edge's commit, so a colliding read gets the old value
      if (S_AXI_ARVALID && S_AXI_ARREADY) begin
        S_AXI_RVALID <= 1'b1;
        if (ar_in_range) begin
          S_AXI_RDATA <= rd_mux[ar_idx];
          S_AXI_RRESP <= RESP_OKAY;
        end else begin
          S_AXI_RDATA <= '0;
          S_AXI_RRESP <= RESP_SLVERR;
        end
      end
    end
  end

endmodule
